// File: rtl/nn_pixel_feeder_pkg.sv
// Shared types and helpers for the nn pixel feeder: FSM states, image constants, pixel conversion.
// Optional build macro NN_FEEDER_BINARIZE_EN switches the conversion to a 0 / 1.0 threshold.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int NN_PIXELS  = 784;
    localparam int NN_CLASSES = 10;

    // Returns a 64-bit word; the caller truncates it to its pixel width.
    function automatic logic [63:0] pix_to_fixed(input logic [7:0] px, input int frac);
        logic [63:0] w;
`ifdef NN_FEEDER_BINARIZE_EN
        w = px[7] ? (64'd1 << frac) : 64'd0;
`else
        w = {56'd0, px} << (frac - 8);
`endif
        return w;
    endfunction

endpackage

// File: rtl/nn_pixel_feeder_if.sv
// Byte-stream input and nn pixel/prediction signals of the feeder.
// master = the feeder itself, slave = the source/nn environment.
interface nn_pixel_feeder_if #(
    parameter int BITS = 24
);
    logic            s_valid;
    logic [7:0]      s_data;
    logic            s_ready;
    logic            nn_rst;
    logic            nn_en;
    logic [BITS-1:0] nn_pixel;
    logic [BITS-1:0] nn_pred;

    modport master (
        input  s_valid, s_data, nn_pred,
        output s_ready, nn_rst, nn_en, nn_pixel
    );

    modport slave (
        output s_valid, s_data, nn_pred,
        input  s_ready, nn_rst, nn_en, nn_pixel
    );
endinterface

// File: rtl/nn_pixel_feeder_fifo.sv
// Synchronous byte FIFO, DEPTH entries (power of two); head is presented combinationally.
// A push while full is taken only when a pop frees the slot in the same cycle.
module nn_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage is cleared so the head never shows X before the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/nn_pixel_feeder.sv
// Feeds one WIDTH-pixel image to the nn, waits DRAIN cycles, then pulses the predicted digit.
// Build macro NN_FEEDER_BINARIZE_EN selects thresholded instead of linear pixel conversion.
import nn_pkg::*;

module nn_pixel_feeder #(
    parameter int BITS  = 24,
    parameter int FRAC  = 16,
    parameter int WIDTH = NN_PIXELS,
    parameter int DEPTH = 4,
    parameter int DRAIN = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    nn_pixel_feeder_if.master   bus,
    output logic [3:0]          result,
    output logic                result_valid,
    output logic                busy
);
    localparam int IW = $clog2(WIDTH + 1);
    localparam int OW = $clog2(WIDTH);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   in_cnt;
    logic [OW-1:0]   out_cnt;
    logic [DW-1:0]   drn_cnt;
    logic [3:0]      result_q;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      head;
    logic            unused_pred;

    nn_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.s_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The DRAIN parameter shadows the state literal, hence the qualified name.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (start) state_nxt = CLEAR;
            CLEAR:         state_nxt = STREAM;
            STREAM:        if (pop && out_cnt == OW'(WIDTH - 1)) state_nxt = nn_pkg::DRAIN;
            nn_pkg::DRAIN: if (drn_cnt == DW'(DRAIN - 1)) state_nxt = DONE;
            DONE:          state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready  = 1'b0;
        pop          = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        if (!reset) begin
            bus.s_ready  = (state == CLEAR || state == STREAM) && !fifo_full &&
                           (in_cnt < IW'(WIDTH));
            pop          = (state == STREAM) && !fifo_empty;
            busy         = (state != IDLE);
            result_valid = (state == DONE);
        end
    end

    assign push         = bus.s_valid && bus.s_ready;
    assign bus.nn_en    = pop;
    assign bus.nn_rst   = reset || (state == CLEAR);
    assign bus.nn_pixel = BITS'(pix_to_fixed(head, FRAC));
    assign result       = result_valid ? bus.nn_pred[3:0] : result_q;
    assign unused_pred  = ^bus.nn_pred[BITS-1:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            drn_cnt  <= '0;
            result_q <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (push) in_cnt  <= in_cnt + IW'(1);
                if (pop)  out_cnt <= out_cnt + OW'(1);
            end
            drn_cnt <= (state == nn_pkg::DRAIN) ? drn_cnt + DW'(1) : '0;
            if (state == DONE) result_q <= bus.nn_pred[3:0];
        end
    end

endmodule

// File: tb/tb_nn_pixel_feeder.sv
// Directed bench for nn_pixel_feeder: full images, stalls, over-offer, ignored start, mid-image reset.
module tb_nn_pixel_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] result;
    logic       result_valid;
    logic       busy;

    nn_pixel_feeder_if #(.BITS(24)) bus ();

    nn_pixel_feeder #(
        .BITS(24), .FRAC(16), .WIDTH(784), .DEPTH(4), .DRAIN(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int i);
        case (i)
            0:       return 8'hFF;
            1:       return 8'h80;
            2:       return 8'h7F;
            default: return 8'((i * 37 + 5) & 255);
        endcase
    endfunction

    // FRAC=16: linear is byte<<8, binarized is 0x010000 or 0.
    function automatic logic [23:0] conv(input logic [7:0] b);
`ifdef NN_FEEDER_BINARIZE_EN
        return (b >= 8'd128) ? 24'h010000 : 24'h000000;
`else
        return {8'h00, b, 8'h00};
`endif
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0]  acc_q [$];
    int          acc_cnt = 0, beats = 0, img_beats = 0, order_errs = 0;
    int          rst_cycles = 0, rv_cnt = 0, first_beat = 0, last_beat = 0, rv_cyc = 0;
    logic [3:0]  rv_val = 4'd0;
    logic [23:0] beat_pix [3];

    always @(negedge clk) begin
        if (reset || !busy) begin
            acc_q.delete();
            img_beats = 0;
        end
        if (!reset) begin
            if (bus.nn_rst) rst_cycles++;
            if (bus.nn_en) begin
                if (img_beats == 0) first_beat = cyc;
                if (img_beats < 3) beat_pix[img_beats] = bus.nn_pixel;
                last_beat = cyc;
                beats++;
                img_beats++;
                if (acc_q.size() == 0) order_errs++;
                else if (bus.nn_pixel !== conv(acc_q.pop_front())) order_errs++;
            end
            if (bus.s_valid && bus.s_ready) begin
                acc_q.push_back(bus.s_data);
                acc_cnt++;
            end
            if (result_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                rv_val = result;
            end
        end
    end

    task automatic run_image(input int n_offer, input bit gaps, input bit mid_start,
                             input int reset_at, input logic [23:0] pred, input string nm);
        int b0, a0, o0, r0, v0, t, start_cyc;
        bit to;
        b0 = beats; a0 = acc_cnt; o0 = order_errs; r0 = rst_cycles; v0 = rv_cnt;
        bus.nn_pred = pred;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < n_offer; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = pix(i);
            to = 1'b0;
            t  = 0;
            forever begin
                @(negedge clk);
                if (bus.s_ready) break;
                @(posedge clk); #1;
                start = 1'b0;
                t++;
                if (t > 40) begin
                    to = 1'b1;
                    break;
                end
            end
            if (to) begin
                if (i < 784) chk({nm, "_accept_timeout"}, i, n_offer);
                break;
            end
            @(posedge clk); #1;
            start = mid_start && (i == 300);
            if (reset_at > 0 && i + 1 == reset_at) begin
                reset = 1'b1;
                bus.s_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk({nm, "_rst_nn_rst_now"}, bus.nn_rst, 1);
                @(posedge clk); #1;
                @(negedge clk);
                chk({nm, "_rst_busy"}, busy, 0);
                chk({nm, "_rst_nn_rst"}, bus.nn_rst, 1);
                chk({nm, "_rst_s_ready"}, bus.s_ready, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                repeat (20) @(negedge clk);
                chk({nm, "_rst_busy_after"}, busy, 0);
                chk({nm, "_rst_no_result"}, rv_cnt - v0, 0);
                return;
            end
            if (gaps && (i % 3 == 2)) begin
                bus.s_valid = 1'b0;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        bus.s_valid = 1'b0;
        start = 1'b0;
        t = 0;
        while (rv_cnt == v0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk({nm, "_latency"}, first_beat - start_cyc, 2);
        chk({nm, "_nn_rst_cycles"}, rst_cycles - r0, 1);
        chk({nm, "_beats"}, beats - b0, 784);
        chk({nm, "_accepted"}, acc_cnt - a0, 784);
        chk({nm, "_order_errs"}, order_errs - o0, 0);
        chk({nm, "_result_pulses"}, rv_cnt - v0, 1);
        chk({nm, "_drain_latency"}, rv_cyc - last_beat, 3);
        chk({nm, "_result"}, rv_val, pred[3:0]);
        chk({nm, "_result_held"}, result, pred[3:0]);
        if (gaps) chk({nm, "_gapped_span"}, (last_beat - first_beat) > 783, 1);
        else      chk({nm, "_span"}, last_beat - first_beat, 783);
    endtask

    logic [23:0] e0, e1, e2;

    initial begin
`ifdef NN_FEEDER_BINARIZE_EN
        e0 = 24'h010000; e1 = 24'h010000; e2 = 24'h000000;
`else
        e0 = 24'h00FF00; e1 = 24'h008000; e2 = 24'h007F00;
`endif
        reset = 1'b1;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.nn_pred = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_nn_rst", bus.nn_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_s_ready", bus.s_ready, 0);
        chk("reset_nn_en", bus.nn_en, 0);
        chk("reset_result_valid", result_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_nn_rst", bus.nn_rst, 0);
        chk("idle_nn_pixel", bus.nn_pixel, 0);
        chk("idle_result", result, 0);
        chk("idle_s_ready", bus.s_ready, 0);

        run_image(784, 1'b0, 1'b0, 0, 24'h000007, "img_a");
        chk("pix_ff", beat_pix[0], e0);
        chk("pix_80", beat_pix[1], e1);
        chk("pix_7f", beat_pix[2], e2);

        run_image(784, 1'b1, 1'b1, 0, 24'h000003, "img_b");
        run_image(800, 1'b0, 1'b0, 0, 24'h000009, "img_c");
        run_image(784, 1'b0, 1'b0, 400, 24'h000002, "img_d");
        run_image(784, 1'b0, 1'b0, 0, 24'h000005, "img_e");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
